// File: rtl/bcd2_seg_decoder_if.sv
// rtl/bcd2_seg_decoder_if.sv - BCD code inputs and seven-segment/dp outputs of the decoder
interface bcd2_seg_decoder_if;
   logic A;
   logic B;
   logic C;
   logic D;
   logic a;
   logic b;
   logic c;
   logic d;
   logic e;
   logic f;
   logic g;
   logic dp;

   modport master (
      output A, B, C, D,
      input  a, b, c, d, e, f, g, dp
   );

   modport slave (
      input  A, B, C, D,
      output a, b, c, d, e, f, g, dp
   );
endinterface

// File: rtl/bcd2_seg_decoder.sv
// rtl/bcd2_seg_decoder.sv - registered BCD to seven-segment decoder, dp flags codes 10..15
module bcd2_seg_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   bcd2_seg_decoder_if.slave   seg
);
   // Pattern bit order is {a,b,c,d,e,f,g,dp}; "off" is all zeros before polarity inversion.
   localparam logic [7:0] OFF_PATTERN = {8{SEG_ACTIVE_LOW}};

   logic [3:0] code;
   logic [7:0] seg_d;
   logic [7:0] seg_q;

   assign code = {seg.A, seg.B, seg.C, seg.D};

   always_comb begin
      seg_d = 8'b0000_0000;
      case (code)
         4'd0:    seg_d = 8'b1111_1100;
         4'd1:    seg_d = 8'b0110_0000;
         4'd2:    seg_d = 8'b1101_1010;
         4'd3:    seg_d = 8'b1111_0010;
         4'd4:    seg_d = 8'b0110_0110;
         4'd5:    seg_d = 8'b1011_0110;
         4'd6:    seg_d = 8'b1011_1110;
         4'd7:    seg_d = 8'b1110_0000;
         4'd8:    seg_d = 8'b1111_1110;
         4'd9:    seg_d = 8'b1111_0110;
         default: seg_d = 8'b0000_0001;
      endcase
      if (SEG_ACTIVE_LOW) begin
         seg_d = ~seg_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= OFF_PATTERN;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg.a  = seg_q[7];
   assign seg.b  = seg_q[6];
   assign seg.c  = seg_q[5];
   assign seg.d  = seg_q[4];
   assign seg.e  = seg_q[3];
   assign seg.f  = seg_q[2];
   assign seg.g  = seg_q[1];
   assign seg.dp = seg_q[0];
endmodule

// File: tb/tb_bcd2_seg_decoder.sv
// tb/tb_bcd2_seg_decoder.sv - directed bench for both output polarities of the decoder
module tb_bcd2_seg_decoder;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   bcd2_seg_decoder_if if_hi ();
   bcd2_seg_decoder_if if_lo ();

   bcd2_seg_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
      .clk (clk),
      .rst (rst),
      .seg (if_hi.slave)
   );

   bcd2_seg_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
      .clk (clk),
      .rst (rst),
      .seg (if_lo.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-computed {a,b,c,d,e,f,g,dp} for digits 0..9, active-high.
   logic [7:0] exp_tbl [10];

   function automatic logic [7:0] obs_hi();
      return {if_hi.a, if_hi.b, if_hi.c, if_hi.d, if_hi.e, if_hi.f, if_hi.g, if_hi.dp};
   endfunction

   function automatic logic [7:0] obs_lo();
      return {if_lo.a, if_lo.b, if_lo.c, if_lo.d, if_lo.e, if_lo.f, if_lo.g, if_lo.dp};
   endfunction

   task automatic drive(input logic [3:0] n, input logic r);
      {if_hi.A, if_hi.B, if_hi.C, if_hi.D} = n;
      {if_lo.A, if_lo.B, if_lo.C, if_lo.D} = n;
      rst = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_tbl = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

      drive(4'b1000, 1'b1);
      tick();
      tick();
      check("reset_hi", obs_hi(), 8'b0000_0000);
      check("reset_lo", obs_lo(), 8'b1111_1111);

      for (int i = 0; i < 10; i++) begin
         drive(4'(i), 1'b0);
         tick();
         check($sformatf("digit_%0d", i), obs_hi(), exp_tbl[i]);
         if (i == 1) begin
            check("digit_1_lo", obs_lo(), 8'b1001_1111);
         end
      end

      drive(4'b1010, 1'b0);
      tick();
      check("invalid_10", obs_hi(), 8'b0000_0001);
      check("invalid_10_lo", obs_lo(), 8'b1111_1110);
      drive(4'b1100, 1'b0);
      tick();
      check("invalid_12", obs_hi(), 8'b0000_0001);
      drive(4'b1111, 1'b0);
      tick();
      check("invalid_15", obs_hi(), 8'b0000_0001);

      drive(4'b1000, 1'b0);
      tick();
      check("eight_before_rst", obs_hi(), 8'b1111_1110);
      drive(4'b1000, 1'b1);
      tick();
      check("midseq_rst_hi", obs_hi(), 8'b0000_0000);
      check("midseq_rst_lo", obs_lo(), 8'b1111_1111);
      tick();
      check("rst_held", obs_hi(), 8'b0000_0000);

      drive(4'b0010, 1'b0);
      tick();
      check("first_after_rst", obs_hi(), 8'hDA);
      drive(4'b1000, 1'b0);
      #2;
      check("glitch_hold_1", obs_hi(), 8'hDA);
      drive(4'b1111, 1'b0);
      #2;
      check("glitch_hold_2", obs_hi(), 8'hDA);
      drive(4'b0111, 1'b0);
      tick();
      check("glitch_settle", obs_hi(), 8'hE0);
      check("glitch_settle_lo", obs_lo(), 8'h1F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bcd2_seg_decoder.md
BCD2_SEG_DECODER -- requirements
Module: bcd2_seg_decoder

Interface
REQ-001 The module SHALL have parameter SEG_ACTIVE_LOW, default 0, meaning when 1 every output (a..g, dp) is driven inverted for common-anode displays.
REQ-002 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, meaning reset, synchronous and active-high.
REQ-004 The module SHALL have port A, input, 1 bit, meaning BCD bit 3 (MSB, weight 8).
REQ-005 The module SHALL have port B, input, 1 bit, meaning BCD bit 2 (weight 4).
REQ-006 The module SHALL have port C, input, 1 bit, meaning BCD bit 1 (weight 2).
REQ-007 The module SHALL have port D, input, 1 bit, meaning BCD bit 0 (LSB, weight 1).
REQ-008 The module SHALL have ports a, b, c, d, e, f, g, each output, 1 bit, meaning standard seven-segment lines (a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle).
REQ-009 The module SHALL have port dp, output, 1 bit, meaning decimal-point segment used as an invalid-code indicator.

Function
REQ-010 The module SHALL form code N = {A,B,C,D} as an unsigned 4-bit value.
REQ-011 Outputs SHALL be registered: values sampled at rising edge k SHALL appear at outputs after edge k, giving 1-cycle latency, and SHALL hold until the next edge.
REQ-012 With SEG_ACTIVE_LOW=0, the registered abcdefg pattern SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-013 For N = 0..9, dp SHALL be 0 (off).
REQ-014 For N = 10..15, all segments a..g SHALL be 0 (blank) and dp SHALL be 1 (lit, error indicator).
REQ-015 With SEG_ACTIVE_LOW=1, every output bit SHALL be the bitwise inverse of the SEG_ACTIVE_LOW=0 value, including the reset value.
REQ-016 Decoding SHALL be purely a function of the current inputs; no history other than the output register SHALL exist.
REQ-017 Input changes between clock edges SHALL NOT affect outputs until the next rising edge, so glitches are never visible on the outputs.
REQ-018 Consecutive input changes on every cycle SHALL each be reflected exactly one cycle later, with no dropped codes.

Reset
REQ-019 When rst=1 at a rising edge, all outputs SHALL become "off": a..g=0 and dp=0 for SEG_ACTIVE_LOW=0, or all 1 for SEG_ACTIVE_LOW=1.
REQ-020 Reset SHALL take priority over decoding: inputs present on a reset edge SHALL be ignored.
REQ-021 After rst falls, the first edge with rst=0 SHALL load the decoded value of the inputs present at that edge.
REQ-022 An assertion of rst mid-sequence SHALL blank the display on that edge, regardless of the previous output value.
REQ-023 Before the first reset, output values are unspecified; the bench SHALL apply reset first.

Verification
REQ-024 Hold rst=1 for 2 cycles with ABCD=1000, then check: a..g=0000000 and dp=0.
REQ-025 Release reset, then sweep ABCD 0000..1001 one per cycle; each abcdefg SHALL match REQ-012 one cycle later with dp=0 (e.g. 0101 gives 1011011).
REQ-026 Apply ABCD = 1010, 1100, then 1111; each SHALL produce abcdefg=0000000 and dp=1 one cycle later.
REQ-027 Apply ABCD=1000 and assert rst on the following edge; outputs SHALL show 1111111 for exactly one cycle, then 0000000 with dp=0.
REQ-028 With SEG_ACTIVE_LOW=1, apply ABCD=0001; outputs SHALL be abcdefg=1001111 with dp=1, and the reset value SHALL be all ones.
REQ-029 Toggle the inputs between clock edges; the outputs SHALL change only on rising edges.
